// File: rtl/hbridge_pkg.sv
// Shared state encoding, fault codes and the low-side gate mask
// for the bridge gate sequencer.
package hbridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_BOOT      = 3'd1,
      ST_PRECHARGE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   localparam logic [3:0] FC_NONE     = 4'h0;
   localparam logic [3:0] FC_SHOOT    = 4'h1;
   localparam logic [3:0] FC_EXT_BASE = 4'h2;

   // Low sides occupy bits [2*n_leg-1:n_leg]
   function automatic logic [31:0] low_side_mask(input int n_leg);
      logic [31:0] m;
      m = ((32'd1 << n_leg) - 32'd1) << n_leg;
      return m;
   endfunction

endpackage

// File: rtl/gate_deadtime.sv
// Single-gate dead-time stage: immediate turn-off, delayed turn-on
// gated by the complementary gate being off.
module gate_deadtime #(
   parameter int DEADTIME = 80,
   parameter int CNT_W    = 16
) (
   input  logic i_clock,
   input  logic i_RESET,
   input  logic i_clear,
   input  logic i_target,
   input  logic i_comp,
   output logic o_gate
);

   localparam logic [CNT_W-1:0] DT = CNT_W'(DEADTIME);

   logic [CNT_W-1:0] r_cnt;
   logic             r_gate;

   always_ff @(posedge i_clock or posedge i_RESET) begin
      if (i_RESET) begin
         r_cnt  <= '0;
         r_gate <= 1'b0;
      end else if (i_clear || !i_target) begin
         r_cnt  <= '0;
         r_gate <= 1'b0;
      end else if (!r_gate) begin
         // Hold at DT until the complementary gate has released
         if (r_cnt == DT) begin
            if (!i_comp) r_gate <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_gate = r_gate;

endmodule

// File: rtl/hbridge_gate_sequencer.sv
// N-leg bridge gate sequencer: start-up FSM, fault latch and
// per-gate dead-time insertion between control law and gate pins.
module hbridge_gate_sequencer
   import hbridge_pkg::*;
#(
   parameter int                   N_LEG         = 2,
   parameter int                   DEADTIME      = 80,
   parameter int                   BOOT_CYCLES   = 1000,
   parameter int                   PRE_CYCLES    = 600,
   parameter logic [2*N_LEG-1:0]   FORCE_PATTERN = 4'b1001,
   parameter int                   N_FAULT       = 2,
   parameter int                   CNT_W         = 16
) (
   input  logic                 i_clock,
   input  logic                 i_RESET,
   input  logic                 i_enable,
   input  logic [2*N_LEG-1:0]   i_mosfet,
   input  logic [N_FAULT-1:0]   i_fault_ext,
   input  logic                 i_fault_clear,
   output logic [2*N_LEG-1:0]   o_Q,
   output logic [2:0]           o_state,
   output logic [3:0]           o_fault_code,
   output logic                 o_running
);

   localparam int               NG        = 2 * N_LEG;
   localparam logic [31:0]      LOW32     = low_side_mask(N_LEG);
   localparam logic [NG-1:0]    LOW_MASK  = LOW32[NG-1:0];
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_timer, w_timer;
   logic [3:0]       r_code, w_code, w_ext_code;
   logic             w_shoot, w_ext;
   logic             w_clear;
   logic [NG-1:0]    w_target, w_gate;

   always_comb begin
      w_shoot    = (r_state == ST_RUN) &&
                   (|(i_mosfet[N_LEG-1:0] & i_mosfet[NG-1:N_LEG]));
      w_ext_code = FC_NONE;
      for (int i = N_FAULT - 1; i >= 0; i--)
         if (i_fault_ext[i]) w_ext_code = FC_EXT_BASE + 4'(i);
      // An idle, disabled bridge does not latch; the fault re-arms on enable
      w_ext = (|i_fault_ext) && (r_state != ST_FAULT) &&
              ((r_state != ST_IDLE) || i_enable);
   end

   always_comb begin
      w_next  = r_state;
      w_timer = '0;
      w_code  = r_code;
      if (w_shoot || w_ext) begin
         w_next = ST_FAULT;
         w_code = w_shoot ? FC_SHOOT : w_ext_code;
      end else begin
         unique case (r_state)
            ST_IDLE: if (i_enable) w_next = ST_BOOT;
            ST_BOOT: begin
               if (!i_enable)               w_next = ST_IDLE;
               else if (r_timer == BOOT_LAST) w_next = ST_PRECHARGE;
               else                         w_timer = r_timer + 1'b1;
            end
            ST_PRECHARGE: begin
               if (!i_enable)              w_next = ST_IDLE;
               else if (r_timer == PRE_LAST) w_next = ST_RUN;
               else                        w_timer = r_timer + 1'b1;
            end
            ST_RUN: if (!i_enable) w_next = ST_IDLE;
            ST_FAULT: begin
               if (i_fault_clear && !i_enable) begin
                  w_next = ST_IDLE;
                  w_code = FC_NONE;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_RESET) begin
      if (i_RESET) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_code  <= FC_NONE;
      end else begin
         r_state <= w_next;
         r_timer <= w_timer;
         r_code  <= w_code;
      end
   end

   always_comb begin
      w_target = '0;
      unique case (r_state)
         ST_BOOT:      w_target = LOW_MASK;
         ST_PRECHARGE: w_target = FORCE_PATTERN;
         ST_RUN:       w_target = i_mosfet;
         default:      w_target = '0;
      endcase
   end

   // Gates drop on the same edge that enters IDLE or FAULT
   assign w_clear = (w_next == ST_IDLE) || (w_next == ST_FAULT);

   for (genvar g = 0; g < NG; g++) begin : g_gate
      gate_deadtime #(
         .DEADTIME (DEADTIME),
         .CNT_W    (CNT_W)
      ) u_gate (
         .i_clock  (i_clock),
         .i_RESET  (i_RESET),
         .i_clear  (w_clear),
         .i_target (w_target[g]),
         .i_comp   (w_gate[(g + N_LEG) % NG]),
         .o_gate   (w_gate[g])
      );
   end

   assign o_Q          = w_gate;
   assign o_state      = r_state;
   assign o_fault_code = r_code;
   assign o_running    = (r_state == ST_RUN);

endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// Scenario bench for hbridge_gate_sequencer with a cycle-level
// reference model stepped alongside the clock.
module tb_hbridge_gate_sequencer;

   localparam int NL   = 2;
   localparam int NG   = 4;
   localparam int NF   = 2;
   localparam int DT   = 80;
   localparam int BOOT = 1000;
   localparam int PRE  = 600;
   localparam logic [NG-1:0] FORCE = 4'b1001;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BOOT  = 3'd1;
   localparam logic [2:0] S_PRE   = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic          clr = 1'b0;
   logic [NG-1:0] mos = '0;
   logic [NF-1:0] fext = '0;
   logic [NG-1:0] q;
   logic [2:0]    st;
   logic [3:0]    code;
   logic          run;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0]    m_st;
   int            m_dwell;
   logic [3:0]    m_code;
   logic [NG-1:0] m_q;
   int            m_high [NG];

   hbridge_gate_sequencer #(
      .N_LEG(NL), .DEADTIME(DT), .BOOT_CYCLES(BOOT), .PRE_CYCLES(PRE),
      .FORCE_PATTERN(FORCE), .N_FAULT(NF), .CNT_W(16)
   ) dut (
      .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_mosfet(mos),
      .i_fault_ext(fext), .i_fault_clear(clr), .o_Q(q), .o_state(st),
      .o_fault_code(code), .o_running(run)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_st = S_IDLE; m_dwell = 0; m_code = 4'h0; m_q = '0;
      for (int g = 0; g < NG; g++) m_high[g] = 0;
   endtask

   // One clock of the reference behaviour, from the inputs held over the edge
   task automatic model_step();
      logic [NG-1:0] tgt, prev;
      logic [2:0] nx;
      bit shoot;
      int ext;
      if (rst) begin
         model_reset();
         return;
      end
      shoot = (m_st == S_RUN) && ((mos[NL-1:0] & mos[NG-1:NL]) != 0);
      ext = -1;
      if (m_st != S_FAULT && !(m_st == S_IDLE && !en))
         for (int i = NF - 1; i >= 0; i--) if (fext[i]) ext = i;
      tgt = '0;
      if (m_st == S_BOOT) for (int k = 0; k < NL; k++) tgt[k+NL] = 1'b1;
      if (m_st == S_PRE) tgt = FORCE;
      if (m_st == S_RUN) tgt = mos;
      nx = m_st;
      if (shoot) begin nx = S_FAULT; m_code = 4'h1; end
      else if (ext >= 0) begin nx = S_FAULT; m_code = 4'(2 + ext); end
      else if (m_st == S_FAULT) begin
         if (clr && !en) begin nx = S_IDLE; m_code = 4'h0; end
      end
      else if (!en) nx = S_IDLE;
      else if (m_st == S_IDLE) nx = S_BOOT;
      else if (m_st == S_BOOT || m_st == S_PRE) begin
         m_dwell++;
         if (m_st == S_BOOT && m_dwell == BOOT) nx = S_PRE;
         if (m_st == S_PRE && m_dwell == PRE) nx = S_RUN;
      end
      if (nx != m_st) m_dwell = 0;
      prev = m_q;
      for (int g = 0; g < NG; g++) begin
         if (nx == S_IDLE || nx == S_FAULT || !tgt[g]) begin
            m_q[g] = 1'b0; m_high[g] = 0;
         end else begin
            m_high[g]++;
            if (!prev[g] && m_high[g] > DT && !prev[(g+NL)%NG]) m_q[g] = 1'b1;
         end
      end
      m_st = nx;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) tick();
      n_cmp++; if (q !== 4'b0000) begin n_bad++; $display("FAIL reset_q got=%b exp=0000", q); end
      n_cmp++; if (st !== S_IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", st); end
      n_cmp++; if (code !== 4'h0) begin n_bad++; $display("FAIL reset_code got=%h exp=0", code); end
      n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL reset_running got=%b exp=0", run); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_startup();
      int boot_n, pre_n, first;
      boot_n = 0; pre_n = 0; first = -1;
      mos = 4'b0110;
      en  = 1'b1;
      for (int i = 1; i <= 1700; i++) begin
         tick();
         n_cmp++;
         if (q !== m_q || st !== m_st) begin
            n_bad++;
            $display("FAIL startup_model cyc=%0d got q=%b st=%0d exp q=%b st=%0d", i, q, st, m_q, m_st);
         end
         n_cmp++;
         if ((q[1:0] & q[3:2]) !== 2'b00) begin n_bad++; $display("FAIL startup_interlock cyc=%0d q=%b", i, q); end
         if (st == S_BOOT) boot_n++;
         if (st == S_PRE) pre_n++;
         if (i == 500) begin
            n_cmp++; if (q !== 4'b1100) begin n_bad++; $display("FAIL boot_pattern got=%b exp=1100", q); end
         end
         if (i == 1600) begin
            n_cmp++; if (q !== 4'b1001) begin n_bad++; $display("FAIL pre_pattern got=%b exp=1001", q); end
         end
         if (first < 0 && q == 4'b0110) first = i;
      end
      n_cmp++; if (boot_n != BOOT) begin n_bad++; $display("FAIL boot_dwell got=%0d exp=%0d", boot_n, BOOT); end
      n_cmp++; if (pre_n != PRE) begin n_bad++; $display("FAIL pre_dwell got=%0d exp=%0d", pre_n, PRE); end
      n_cmp++;
      if (first != 1 + BOOT + PRE + DT + 1) begin
         n_bad++; $display("FAIL first_run_gate got=%0d exp=%0d", first, 1 + BOOT + PRE + DT + 1);
      end
      n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL running got=%b exp=1", run); end
   endtask

   task automatic test_glitch();
      int hi;
      mos = 4'b0010;
      repeat (100) tick();
      for (int p = 0; p < 2; p++) begin
         hi = 0;
         mos = 4'b0011;
         repeat (p == 0 ? 50 : 100) begin
            tick();
            if (q[0]) hi++;
            n_cmp++;
            if (q !== m_q) begin n_bad++; $display("FAIL glitch_model got=%b exp=%b", q, m_q); end
         end
         mos = 4'b0010;
         repeat (100) begin tick(); if (q[0]) hi++; end
         n_cmp++;
         if (hi != (p == 0 ? 0 : 100 - DT)) begin
            n_bad++; $display("FAIL glitch_high_time pulse=%0d got=%0d exp=%0d", p == 0 ? 50 : 100, hi, p == 0 ? 0 : 100 - DT);
         end
      end
      n_cmp++; if (st !== S_RUN) begin n_bad++; $display("FAIL glitch_state got=%0d exp=3", st); end
   endtask

   task automatic test_random_run();
      logic [NG-1:0] pat;
      int hold;
      for (int s = 0; s < 40; s++) begin
         pat = '0;
         for (int k = 0; k < NL; k++) begin
            case ($urandom_range(0, 2))
               1: pat[k] = 1'b1;
               2: pat[k+NL] = 1'b1;
               default: ;
            endcase
         end
         mos  = pat;
         hold = $urandom_range(1, 160);
         repeat (hold) begin
            tick();
            n_cmp++;
            if (q !== m_q || st !== m_st) begin
               n_bad++; $display("FAIL random_model pat=%b got q=%b st=%0d exp q=%b st=%0d", pat, q, st, m_q, m_st);
            end
            n_cmp++;
            if ((q[1:0] & q[3:2]) !== 2'b00) begin n_bad++; $display("FAIL random_interlock q=%b", q); end
         end
      end
   endtask

   task automatic test_shoot_through();
      mos = 4'b0110;
      repeat (100) tick();
      mos = 4'b0111;
      tick();
      n_cmp++; if (st !== S_FAULT) begin n_bad++; $display("FAIL shoot_state got=%0d exp=4", st); end
      n_cmp++; if (code !== 4'h1) begin n_bad++; $display("FAIL shoot_code got=%h exp=1", code); end
      tick();
      n_cmp++; if (q !== 4'b0000) begin n_bad++; $display("FAIL shoot_gates got=%b exp=0000", q); end
      clr = 1'b1;
      tick();
      n_cmp++; if (st !== S_FAULT || code !== 4'h1) begin
         n_bad++; $display("FAIL clear_ignored got st=%0d code=%h exp st=4 code=1", st, code);
      end
      en = 1'b0;
      tick();
      n_cmp++; if (st !== S_IDLE || code !== 4'h0) begin
         n_bad++; $display("FAIL clear_accepted got st=%0d code=%h exp st=0 code=0", st, code);
      end
      clr = 1'b0;
      mos = 4'b0000;
      tick();
   endtask

   task automatic test_ext_fault();
      en = 1'b1;
      repeat (11) tick();
      n_cmp++; if (st !== S_BOOT) begin n_bad++; $display("FAIL ext_pre_state got=%0d exp=1", st); end
      fext = 2'b11;
      tick();
      n_cmp++; if (st !== S_FAULT || code !== 4'h2) begin
         n_bad++; $display("FAIL ext_latch got st=%0d code=%h exp st=4 code=2", st, code);
      end
      fext = 2'b10;
      repeat (5) tick();
      n_cmp++; if (code !== 4'h2) begin n_bad++; $display("FAIL ext_hold got=%h exp=2", code); end
      en = 1'b0; clr = 1'b1;
      tick();
      n_cmp++; if (st !== S_IDLE || code !== 4'h0) begin
         n_bad++; $display("FAIL ext_clear_active got st=%0d code=%h exp st=0 code=0", st, code);
      end
      clr = 1'b0; en = 1'b1;
      tick();
      n_cmp++; if (st !== S_FAULT || code !== 4'h3) begin
         n_bad++; $display("FAIL ext_relatch got st=%0d code=%h exp st=4 code=3", st, code);
      end
      fext = 2'b00; en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      n_cmp++; if (st !== S_IDLE) begin n_bad++; $display("FAIL ext_final got=%0d exp=0", st); end
   endtask

   task automatic test_enable_drop();
      int boot_n;
      mos = 4'b0110;
      en  = 1'b1;
      repeat (BOOT + 300) tick();
      n_cmp++; if (st !== S_PRE || q !== 4'b1001) begin
         n_bad++; $display("FAIL drop_pre got st=%0d q=%b exp st=2 q=1001", st, q);
      end
      en = 1'b0;
      tick();
      n_cmp++; if (st !== S_IDLE || q !== 4'b0000) begin
         n_bad++; $display("FAIL drop_idle got st=%0d q=%b exp st=0 q=0000", st, q);
      end
      en = 1'b1;
      boot_n = 0;
      for (int i = 0; i < BOOT + 20; i++) begin
         tick();
         if (st == S_BOOT) boot_n++;
         if (st == S_PRE) break;
      end
      n_cmp++; if (boot_n != BOOT || st !== S_PRE) begin
         n_bad++; $display("FAIL restart_boot got dwell=%0d st=%0d exp dwell=%0d st=2", boot_n, st, BOOT);
      end
      en = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      mos = 4'b0110;
      en  = 1'b1;
      repeat (1700) tick();
      n_cmp++; if (st !== S_RUN || q !== 4'b0110) begin
         n_bad++; $display("FAIL pre_reset got st=%0d q=%b exp st=3 q=0110", st, q);
      end
      #3 rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (q !== 4'b0000 || st !== S_IDLE || code !== 4'h0 || run !== 1'b0) begin
         n_bad++; $display("FAIL async_reset got q=%b st=%0d code=%h run=%b exp all 0", q, st, code, run);
      end
      #2 rst = 1'b0;
      en = 1'b0;
      tick();
      n_cmp++; if (st !== m_st || q !== m_q) begin
         n_bad++; $display("FAIL post_reset got st=%0d q=%b exp st=%0d q=%b", st, q, m_st, m_q);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_glitch();
      test_random_run();
      test_shoot_through();
      test_ext_fault();
      test_enable_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
